mem_access_stage: RTL and testbench

- MEM stage of the 64-bit pipelined RV64I core. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Drives a req/ack data-memory port. It aligns store data and byte strobes, then extracts and sign- or zero-extends load data.
- Holds the pipeline with mem_stall while an access is outstanding. Owns the MEM/WB pipeline register and produces the final writeback value.

---
 rtl/rv64_mem_pkg.sv | 48 ++++
 rtl/load_extend.sv | 36 +++
 rtl/mem_access_stage.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv64_mem_pkg.sv
// Shared definitions for the RV64I MEM stage.
// Contents:
//   - funct3 size/sign codes for loads and stores
//   - MEM FSM state encoding
//   - byte-strobe base patterns
//   - access_legal(): alignment and encoding check for one access
package rv64_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  // Strobe patterns for an access at byte offset 0.
  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0F;
  localparam logic [7:0] STRB_D = 8'hFF;

  // funct3[1:0] encodes the access size for both loads and stores.
  // Stores have no unsigned variants, and load code 111 does not exist.
  function automatic logic access_legal(input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [2:0] off);
    logic ok;
    ok = 1'b1;
    if (is_store && f3[2])
      ok = 1'b0;
    if (!is_store && (f3 == 3'b111))
      ok = 1'b0;
    case (f3[1:0])
      2'b01:   if (off[0])           ok = 1'b0;
      2'b10:   if (off[1:0] != 2'b0) ok = 1'b0;
      2'b11:   if (off != 3'b0)      ok = 1'b0;
      default: ;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data extraction for the MEM stage.
// Purpose:
//   Shifts the addressed bytes of a 64-bit read doubleword down to bit 0,
//   then sign- or zero-extends them according to funct3.
// Ports:
//   i_rdata  - doubleword returned by data memory
//   i_off    - byte offset of the access within the doubleword
//   i_funct3 - load size/sign code
//   o_value  - 64-bit extended load result
module load_extend
  import rv64_mem_pkg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [2:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [63:0] o_value
);

  logic [63:0] w_raw;

  assign w_raw = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_value = w_raw;
    case (i_funct3)
      F3_B:    o_value = {{56{w_raw[7]}},  w_raw[7:0]};
      F3_H:    o_value = {{48{w_raw[15]}}, w_raw[15:0]};
      F3_W:    o_value = {{32{w_raw[31]}}, w_raw[31:0]};
      F3_BU:   o_value = {56'd0, w_raw[7:0]};
      F3_HU:   o_value = {48'd0, w_raw[15:0]};
      F3_WU:   o_value = {32'd0, w_raw[31:0]};
      default: o_value = w_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 64-bit pipelined RV64I core.
// Purpose:
//   - Classifies the instruction held in EX/MEM.
//   - Issues aligned load/store requests on the data-memory port.
//   - Stalls upstream while an access is outstanding.
//   - Writes the MEM/WB pipeline register.
// Ports:
//   clk, rst                  - clock, async active-high reset
//   *_in                      - EX/MEM pipeline register contents
//   dmem_*                    - data-memory request/ack port
//   mem_stall                 - combinational hold for upstream registers
//   reg_write_out, rd_addr_out, wb_data_out,
//   misaligned_out, bus_err_out - MEM/WB pipeline register
//   dbg_state                 - current FSM state, for observation only
//
// Handshake: dmem_req rises on the edge after a legal access is seen in
// IDLE. dmem_we/addr/wdata/wstrb stay constant while dmem_req is 1.
// Memory completes the access with a single-cycle dmem_ack, with dmem_rdata
// valid in that same cycle. If no ack arrives within TIMEOUT_CYCLES WAIT
// cycles, the request is withdrawn and a bus error is retired. A dmem_ack
// seen while no request is outstanding has no effect.
module mem_access_stage
  import rv64_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] alu_result_in,
  input  logic [63:0] mem_address_in,
  input  logic [63:0] mem_write_data_in,
  input  logic        reg_write_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [2:0]  funct3_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        mem_stall,
  output logic        reg_write_out,
  output logic [4:0]  rd_addr_out,
  output logic [63:0] wb_data_out,
  output logic        misaligned_out,
  output logic        bus_err_out,
  output mem_state_t  dbg_state
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  mem_state_t  r_state, w_state_nxt;
  logic [15:0] r_cnt;

  logic        r_req, r_we;
  logic [63:0] r_addr, r_wdata;
  logic [7:0]  r_wstrb;

  logic [2:0]  r_f3, r_off;
  logic [4:0]  r_rd;
  logic        r_rw, r_m2r;
  logic [63:0] r_alu;

  logic        r_wb_rw, r_wb_mis, r_wb_berr;
  logic [4:0]  r_wb_rd;
  logic [63:0] r_wb_data;

  logic        w_is_store, w_is_load, w_is_mem, w_legal;
  logic [2:0]  w_off;
  logic [7:0]  w_strb;
  logic [63:0] w_wdata_lane, w_load_ext;
  logic        w_timeout;
  logic        w_start, w_done, w_tmo, w_count;

  logic        w_wb_rw, w_wb_mis, w_wb_berr;
  logic [4:0]  w_wb_rd;
  logic [63:0] w_wb_data;

  // Store wins when both mem_write_in and mem_read_in are set.
  assign w_is_store   = mem_write_in;
  assign w_is_load    = !mem_write_in && mem_read_in;
  assign w_is_mem     = w_is_store || w_is_load;
  assign w_off        = mem_address_in[2:0];
  assign w_legal      = access_legal(w_is_store, funct3_in, w_off);
  assign w_wdata_lane = mem_write_data_in << {w_off, 3'b000};
  assign w_timeout    = (r_cnt == CNT_LAST);

  always_comb begin
    w_strb = STRB_D;
    case (funct3_in[1:0])
      2'b00:   w_strb = STRB_B << w_off;
      2'b01:   w_strb = STRB_H << w_off;
      2'b10:   w_strb = STRB_W << w_off;
      default: w_strb = STRB_D;
    endcase
  end

  load_extend u_load_extend (
    .i_rdata  (dmem_rdata),
    .i_off    (r_off),
    .i_funct3 (r_f3),
    .o_value  (w_load_ext)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // FSM: next state, stall and control strobes
  always_comb begin
    w_state_nxt = r_state;
    mem_stall   = 1'b0;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    w_count     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_mem && w_legal) begin
          mem_stall   = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // ack takes precedence over a timeout in the same cycle
        if (dmem_ack) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          mem_stall = 1'b1;
          w_count   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // MEM/WB next value; a bubble unless something retires this cycle.
  always_comb begin
    w_wb_rw   = 1'b0;
    w_wb_rd   = 5'd0;
    w_wb_data = 64'd0;
    w_wb_mis  = 1'b0;
    w_wb_berr = 1'b0;
    if (r_state == ST_IDLE) begin
      if (!w_is_mem) begin
        w_wb_rw   = reg_write_in;
        w_wb_rd   = rd_addr_in;
        w_wb_data = alu_result_in;
      end else if (!w_legal) begin
        w_wb_rd  = rd_addr_in;
        w_wb_mis = 1'b1;
      end
    end else if (w_done) begin
      w_wb_rw   = r_rw;
      w_wb_rd   = r_rd;
      w_wb_data = r_m2r ? w_load_ext : r_alu;
    end else if (w_tmo) begin
      w_wb_rd   = r_rd;
      w_wb_berr = 1'b1;
    end
  end

  // Request port, captured access context and timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_wstrb <= 8'd0;
      r_f3    <= 3'd0;
      r_off   <= 3'd0;
      r_rd    <= 5'd0;
      r_rw    <= 1'b0;
      r_m2r   <= 1'b0;
      r_alu   <= 64'd0;
      r_cnt   <= 16'd0;
    end else begin
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= w_is_store;
        r_addr  <= {mem_address_in[63:3], 3'b000};
        r_wdata <= w_is_store ? w_wdata_lane : 64'd0;
        r_wstrb <= w_is_store ? w_strb : 8'd0;
        r_f3    <= funct3_in;
        r_off   <= w_off;
        r_rd    <= rd_addr_in;
        r_rw    <= reg_write_in;
        r_m2r   <= mem_to_reg_in;
        r_alu   <= alu_result_in;
        r_cnt   <= 16'd0;
      end else if (w_done || w_tmo) begin
        r_req <= 1'b0;
      end else if (w_count) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_rw   <= 1'b0;
      r_wb_rd   <= 5'd0;
      r_wb_data <= 64'd0;
      r_wb_mis  <= 1'b0;
      r_wb_berr <= 1'b0;
    end else begin
      r_wb_rw   <= w_wb_rw;
      r_wb_rd   <= w_wb_rd;
      r_wb_data <= w_wb_data;
      r_wb_mis  <= w_wb_mis;
      r_wb_berr <= w_wb_berr;
    end
  end

  assign dmem_req       = r_req;
  assign dmem_we        = r_we;
  assign dmem_addr      = r_addr;
  assign dmem_wdata     = r_wdata;
  assign dmem_wstrb     = r_wstrb;
  assign reg_write_out  = r_wb_rw;
  assign rd_addr_out    = r_wb_rd;
  assign wb_data_out    = r_wb_data;
  assign misaligned_out = r_wb_mis;
  assign bus_err_out    = r_wb_berr;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage (TIMEOUT_CYCLES = 4).
// - A driver presents EX/MEM contents and holds them while mem_stall is 1.
// - A memory responder acks after a planned delay, or never.
// - A monitor compares every MEM/WB write against an expected queue.
// Expectations come from a reference model built on the access rules
// (size in bytes, offset modulo size, shift/mask arithmetic).
module tb_mem_access_stage;
  import rv64_mem_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] alu_result_in, mem_address_in, mem_write_data_in;
  logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
  logic [4:0]  rd_addr_in;
  logic [2:0]  funct3_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wstrb;
  logic        mem_stall, reg_write_out, misaligned_out, bus_err_out;
  logic [4:0]  rd_addr_out;
  logic [63:0] wb_data_out;
  mem_state_t  dbg_state;

  int checks = 0;
  int errors = 0;

  // {reg_write, rd, wb_data, misaligned, bus_err}
  logic [71:0]  exp_q[$];
  // {we, addr, wstrb, wdata}
  logic [136:0] req_q[$];

  int          plan_delay = 0;
  bit          plan_noack = 0;
  logic [63:0] plan_rdata = '0;
  bit          presenting = 0;
  bit          resp_en = 1;
  logic        force_ack = 1'b0;
  logic [63:0] force_rdata = '0;

  mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk               (clk),
    .rst               (rst),
    .alu_result_in     (alu_result_in),
    .mem_address_in    (mem_address_in),
    .mem_write_data_in (mem_write_data_in),
    .reg_write_in      (reg_write_in),
    .rd_addr_in        (rd_addr_in),
    .funct3_in         (funct3_in),
    .mem_read_in       (mem_read_in),
    .mem_write_in      (mem_write_in),
    .mem_to_reg_in     (mem_to_reg_in),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_wstrb        (dmem_wstrb),
    .dmem_ack          (dmem_ack),
    .dmem_rdata        (dmem_rdata),
    .mem_stall         (mem_stall),
    .reg_write_out     (reg_write_out),
    .rd_addr_out       (rd_addr_out),
    .wb_data_out       (wb_data_out),
    .misaligned_out    (misaligned_out),
    .bus_err_out       (bus_err_out),
    .dbg_state         (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_illegal(input bit store, input logic [2:0] f3, input logic [2:0] off);
    if (store && f3 >= 3'd4) return 1;
    if (!store && f3 == 3'd7) return 1;
    return (int'(off) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [63:0] load_value(input logic [63:0] rd, input logic [2:0] f3,
                                             input logic [2:0] off);
    logic [63:0] raw, mask;
    int n;
    n   = nbytes(f3);
    raw = rd >> (8 * int'(off));
    if (n == 8) return raw;
    mask = (64'd1 << (8 * n)) - 64'd1;
    raw  = raw & mask;
    if (f3 < 3'd4 && raw[8*n-1]) raw = raw | ~mask;
    return raw;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [63:0] alu, input logic [63:0] addr, input logic [63:0] wd,
                       input logic rw, input logic [4:0] rd, input logic [2:0] f3,
                       input logic mr, input logic mw, input logic m2r,
                       input int delay, input bit noack, input logic [63:0] rdata);
    logic [2:0]  off;
    int          exp_stall, n;
    bit          store, mem;
    logic [7:0]  strb;
    logic [63:0] wb;
    off   = addr[2:0];
    store = mw;
    mem   = mw || mr;
    exp_stall = 0;
    if (!mem) begin
      exp_q.push_back({rw, rd, alu, 1'b0, 1'b0});
    end else if (is_illegal(store, f3, off)) begin
      exp_q.push_back({1'b0, rd, 64'd0, 1'b1, 1'b0});
    end else begin
      strb = store ? 8'(((1 << nbytes(f3)) - 1) << off) : 8'h00;
      req_q.push_back({store, {addr[63:3], 3'b000}, strb,
                       store ? (wd << (8 * int'(off))) : 64'd0});
      plan_delay = delay;
      plan_noack = noack || (delay >= T);
      plan_rdata = rdata;
      if (plan_noack) begin
        exp_stall = T;
        exp_q.push_back({1'b0, rd, 64'd0, 1'b0, 1'b1});
      end else begin
        exp_stall = 1 + delay;
        wb = m2r ? load_value(rdata, f3, off) : alu;
        exp_q.push_back({rw, rd, wb, 1'b0, 1'b0});
      end
    end
    @(posedge clk); #1;
    alu_result_in     = alu;
    mem_address_in    = addr;
    mem_write_data_in = wd;
    reg_write_in      = rw;
    rd_addr_in        = rd;
    funct3_in         = f3;
    mem_read_in       = mr;
    mem_write_in      = mw;
    mem_to_reg_in     = m2r;
    presenting        = 1;
    n = 0;
    forever begin
      @(negedge clk);
      if (!mem_stall) break;
      n++;
      if (n > 40) begin
        errors++;
        $display("FAIL stall_timeout actual=%0d required<=%0d", n, exp_stall);
        break;
      end
    end
    chk("stall_cycles", 137'(n), 137'(exp_stall));
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    int k;
    logic [136:0] cur;
    k = 0;
    cur = '0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!resp_en) begin
        dmem_ack   = force_ack;
        dmem_rdata = force_rdata;
        k = 0;
      end else if (rst || !dmem_req) begin
        dmem_ack = 1'b0;
        k = 0;
      end else begin
        if (k == 0) begin
          if (req_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_req actual=req required=none addr=%h", dmem_addr);
            cur = {dmem_we, dmem_addr, dmem_wstrb, dmem_wdata};
          end else begin
            cur = req_q.pop_front();
            chk("dmem_request", {dmem_we, dmem_addr, dmem_wstrb, dmem_wdata}, cur);
          end
        end else begin
          chk("dmem_req_stable", {dmem_we, dmem_addr, dmem_wstrb, dmem_wdata}, cur);
        end
        if (!plan_noack && k == plan_delay) begin
          dmem_ack   = 1'b1;
          dmem_rdata = plan_rdata;
        end else begin
          dmem_ack   = 1'b0;
          dmem_rdata = {$urandom, $urandom};
        end
        k++;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    bit prev_commit, prev_bubble;
    logic [71:0] e;
    prev_commit = 0;
    prev_bubble = 0;
    forever begin
      @(negedge clk);
      if (prev_commit) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL wb_unexpected actual=rw%0d required=empty_queue", reg_write_out);
        end else begin
          e = exp_q.pop_front();
          chk("wb_flags", {reg_write_out, misaligned_out, bus_err_out}, {e[71], e[1], e[0]});
          chk("wb_data", wb_data_out, e[65:2]);
          if (e[71]) chk("wb_rd", rd_addr_out, e[70:66]);
        end
      end else if (prev_bubble) begin
        chk("wb_bubble", {reg_write_out, misaligned_out, bus_err_out}, 3'b000);
      end
      prev_commit = presenting && !rst && !mem_stall;
      prev_bubble = presenting && !rst && mem_stall;
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [63:0] a, rdat;
    logic [2:0]  f3;
    int kind;
    rst = 1'b1;
    alu_result_in = '0; mem_address_in = '0; mem_write_data_in = '0;
    reg_write_in = 0; rd_addr_in = '0; funct3_in = '0;
    mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0;
    #12;
    chk("reset_port", {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb}, 137'd0);
    chk("reset_wb", {reg_write_out, rd_addr_out, wb_data_out, misaligned_out, bus_err_out}, 137'd0);
    chk("reset_state", {dbg_state, mem_stall}, {ST_IDLE, 1'b0});
    @(negedge clk);
    rst = 1'b0;

    // directed cases
    issue(64'h1234, 64'h0, 64'h0, 1, 5'd5, 3'b000, 0, 0, 0, 0, 0, 64'h0);
    issue(64'h55, 64'h1002, 64'hBEEF, 0, 5'd3, 3'b001, 0, 1, 0, 0, 0, 64'h0);
    issue(64'h0, 64'h2005, 64'h0, 1, 5'd7, 3'b000, 1, 0, 1, 0, 0, 64'h0000_8000_0000_0000);
    issue(64'h0, 64'h2005, 64'h0, 1, 5'd7, 3'b100, 1, 0, 1, 0, 0, 64'h0000_8000_0000_0000);
    issue(64'h0, 64'h3002, 64'h0, 1, 5'd8, 3'b010, 1, 0, 1, 0, 0, 64'h0);
    issue(64'h0, 64'h4000, 64'h0, 1, 5'd9, 3'b011, 1, 0, 1, 0, 1, 64'h0);
    issue(64'h0, 64'h4008, 64'h0, 1, 5'd10, 3'b011, 1, 0, 1, T - 1, 0, 64'hCAFE_F00D_1234_5678);
    issue(64'h77, 64'h5003, 64'h1, 1, 5'd11, 3'b100, 1, 1, 0, 0, 0, 64'h0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 3);
      f3   = 3'($urandom_range(0, 7));
      a    = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[2:0] = a[2:0] & ~3'(nbytes(f3) - 1);
      rdat = {$urandom, $urandom};
      issue({$urandom, $urandom}, a, {$urandom, $urandom} >> (64 - 8 * nbytes(f3)),
            1'($urandom), 5'($urandom), f3,
            kind == 1 || kind == 3, kind >= 2, kind == 1,
            $urandom_range(0, 3), $urandom_range(0, 7) == 0, rdat);
    end
    @(posedge clk); #1;
    presenting = 0;
    mem_read_in = 0; mem_write_in = 0; reg_write_in = 0;
    repeat (3) @(posedge clk);
    chk("queues_drained", 137'({exp_q.size(), req_q.size()}), 137'd0);

    // reset while a request is outstanding, then a stray ack
    @(posedge clk); #1;
    req_q.push_back({1'b0, 64'h6000, 8'h00, 64'd0});
    plan_noack = 1;
    mem_address_in = 64'h6000; funct3_in = 3'b011; mem_read_in = 1;
    reg_write_in = 1; rd_addr_in = 5'd9; mem_to_reg_in = 1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("wait_before_rst", {dmem_req, dbg_state}, {1'b1, ST_WAIT});
    rst = 1'b1;
    #1;
    chk("rst_in_wait_port", {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb}, 137'd0);
    chk("rst_in_wait_wb", {reg_write_out, rd_addr_out, wb_data_out, misaligned_out, bus_err_out}, 137'd0);
    mem_read_in = 0; reg_write_in = 0; alu_result_in = '0; rd_addr_in = '0; mem_to_reg_in = 0;
    @(negedge clk);
    rst = 1'b0;
    resp_en = 0;
    force_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    force_ack = 1'b1;
    #1;
    chk("stray_ack_stall", {mem_stall, dbg_state}, {1'b0, ST_IDLE});
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_no_write",
        {dmem_req, reg_write_out, wb_data_out, misaligned_out, bus_err_out}, 137'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
